and_gate_checker: RTL and testbench

Synthesizable self-checking response monitor for a 2-input AND gate. It drives `a`/`b` into the gate under test, waits a programmable settle time, samples `f`, and compares it against the expected `a & b`. Every run steps exhaustively through the four input vectors. It reports per-vector failures, a cumulative error count and a pass flag, so gate-level checks run on hardware and in simulation without a behavioural testbench.

---
 rtl/gate_chk_pkg.sv | 26 ++
 rtl/settle_timer.sv | 39 +++
 rtl/and_gate_checker.sv | 118 +++++++++++
 tb/tb_and_gate_checker.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared types and helpers for the small-gate self-checkers.
//   state_t        : checker run state (IDLE / RUN)
//   NUM_VECTORS    : exhaustive vector count for a 2-input gate
//   VEC_IDX_W      : width of the vector index
//   expected_and() : reference function for the AND checker. Sibling OR/XOR
//                    checkers add their own reference function next to it.
package gate_chk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_IDX_W   = 2;

    typedef logic [VEC_IDX_W-1:0] vec_idx_t;

    // The last vector index ends the run.
    localparam vec_idx_t LAST_VEC = vec_idx_t'(NUM_VECTORS - 1);

    function automatic logic expected_and(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that marks the last cycle of a settle
// window.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   load : reload the counter with SETTLE_CYCLES-1 (takes priority over en)
//   en   : decrement while nonzero
//   tc   : terminal count, high while the counter reads 0
// When loaded at edge E, tc is high during the cycle that follows edge
// E+SETTLE_CYCLES-1. The next edge is therefore the last edge of a window that
// is exactly SETTLE_CYCLES cycles long.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    // A window of one cycle still needs a 1-bit counter. That counter stays at 0.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/and_gate_checker.sv
// and_gate_checker: exhaustive response monitor for a 2-input AND gate.
// It steps a/b through 00, 01, 10, 11. Each vector is held SETTLE_CYCLES cycles.
// f is sampled on the last edge of each window and compared to a & b.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : run request, accepted only while idle
//   f         : output of the gate under test
//   a, b      : registered stimulus to the gate
//   busy      : run in progress
//   done      : one-cycle pulse when a run ends
//   pass      : last completed run had no mismatches
//   fail_vec  : bit k set if vector k mismatched in the last run
//   err_count : saturating count of mismatches since reset
module and_gate_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   f,
    output logic                   a,
    output logic                   b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] fail_vec,
    output logic [ERR_W-1:0]       err_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    state_t                 state, state_nxt;
    vec_idx_t               vec_idx;
    logic [NUM_VECTORS-1:0] fail_acc;
    logic                   tc;
    logic                   accept;
    logic                   sample;
    logic                   last_vec;
    logic                   mismatch;
    logic                   timer_load;
    logic [NUM_VECTORS-1:0] fail_bit;
    logic [NUM_VECTORS-1:0] fail_final;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (state == ST_RUN),
        .tc   (tc)
    );

    // Case inequality makes an X or Z on f count as a mismatch in simulation.
    assign mismatch   = (f !== expected_and(a, b));
    assign accept     = (state == ST_IDLE) && start;
    assign sample     = (state == ST_RUN) && tc;
    assign last_vec   = (vec_idx == LAST_VEC);
    assign timer_load = accept || (sample && !last_vec);
    assign fail_bit   = NUM_VECTORS'(mismatch) << vec_idx;
    // The result of vector 3 is folded in on the same edge that reports it.
    assign fail_final = fail_acc | fail_bit;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)               state_nxt = ST_RUN;
            ST_RUN:  if (sample && last_vec)  state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_idx   <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            fail_acc  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                vec_idx  <= '0;
                a        <= 1'b0;
                b        <= 1'b0;
                fail_acc <= '0;
            end
            if (sample) begin
                if (mismatch && (err_count != ERR_MAX))
                    err_count <= err_count + 1'b1;
                if (last_vec) begin
                    // a/b keep showing vector 11 until the next start.
                    done     <= 1'b1;
                    fail_vec <= fail_final;
                    pass     <= (fail_final == '0);
                end else begin
                    fail_acc <= fail_final;
                    vec_idx  <= vec_idx + 1'b1;
                    {a, b}   <= vec_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_and_gate_checker.sv
// tb_and_gate_checker: randomized check of and_gate_checker.
// The gate under test is a 4-entry truth table indexed by {a,b}. The
// expected result of a run is obtained by comparing that table against the
// AND truth table 4'b1000.
module tb_and_gate_checker;

    localparam int S  = 2;
    localparam int S2 = 1;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] tt;
    logic       f, a, b, busy, done, pass;
    logic [3:0] fail_vec;
    logic [7:0] err_count;

    logic       start2;
    logic       f2, a2, b2, busy2, done2, pass2;
    logic [3:0] fail_vec2;
    logic [1:0] err_count2;

    int total = 0;
    int bad   = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    assign f  = tt[{a, b}];
    assign f2 = 1'b1;

    and_gate_checker #(.SETTLE_CYCLES(S), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .f(f), .a(a), .b(b),
        .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec),
        .err_count(err_count)
    );

    and_gate_checker #(.SETTLE_CYCLES(S2), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .f(f2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_vec(fail_vec2),
        .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one check of the gate described by table g.
    // noise: start is toggled at random while the run is busy.
    // chain: start is left high at the end, so the next run begins at once.
    task automatic run_vec(input logic [3:0] g, input bit noise, input bit chain);
        logic [3:0] exp_fv;
        tt    = g;
        start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 4 * S; c++) begin
            #1;
            chk("vec", {30'd0, a, b}, 32'(c / S));
            chk("busy_run", busy, 1);
            chk("no_done", done, 0);
            start = noise ? 1'($urandom) : chain;
            @(posedge clk);
        end
        #1;
        exp_fv  = g ^ 4'b1000;
        exp_err = exp_err + $countones(exp_fv);
        if (exp_err > 255) exp_err = 255;
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("fail_vec", fail_vec, exp_fv);
        chk("pass", pass, exp_fv == 4'b0);
        chk("err_count", err_count, exp_err);
        chk("ab_hold", {a, b}, 2'b11);
        start = chain;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; start2 = 1'b0; tt = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fv", fail_vec, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ab", {a, b}, 0);

        // When reset and start arrive together, reset wins.
        start = 1'b1;
        @(posedge clk); #1;
        chk("rst_start_busy", busy, 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        run_vec(4'b1000, 0, 0);            // correct AND gate
        run_vec(4'b1111, 0, 0);            // f stuck at 1
        run_vec(4'b1000, 0, 0);            // repaired gate
        run_vec(4'b1110, 0, 0);            // OR gate in place of AND
        run_vec(4'b0000, 1, 0);            // f stuck at 0, start noise mid-run
        for (int i = 0; i < 6; i++)
            run_vec(4'($urandom), 1, 0);   // random faulty tables
        // start held high, so the runs follow one another with no gap
        run_vec(4'b1000, 0, 1);
        run_vec(4'b0110, 0, 1);
        run_vec(4'b1000, 0, 0);
        @(posedge clk);

        // Reset in the middle of a run
        tt = 4'b0111;
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 0;
        chk("mid_busy", busy, 0);
        chk("mid_err", err_count, 0);
        chk("mid_fv", fail_vec, 0);
        chk("mid_pass", pass, 0);
        chk("mid_ab", {a, b}, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("mid_no_done", seen, 0);
        run_vec(4'b1000, 0, 0);

        // Second instance (SETTLE_CYCLES=1, ERR_W=2). f is stuck at 1 and start
        // is held high. err_count must saturate at 3 and not wrap.
        start2 = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (done2) seen = 1;
            end
            chk("sat_done_seen", seen, 1);
            chk("sat_err", err_count2, (3 * n > 3) ? 3 : 3 * n);
            chk("sat_fv", fail_vec2, 4'b0111);
            chk("sat_pass", pass2, 0);
        end
        start2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
